// File: rtl/parity_tx_pkg.sv
// Shared types and constants for the parity serial transmitter.
package parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int         FRAME_BITS = 7;
  localparam logic [6:0] SEG_E      = 7'b0000110;
  localparam logic [6:0] SEG_O      = 7'b1000000;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;

endpackage

// File: rtl/parity_tx_bit_timer.sv
// Bit-period counter: bit_done_o pulses on the last cycle of each CLKS_PER_BIT period.
// Zero latency (combinational pulse off the count); holds at 0 while not running or on restart.
module parity_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic run_i,
  output logic bit_done_o
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (start_i || !run_i) begin
      cnt_d = '0;
    end else if (bit_done_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/parity_tx.sv
// Nibble serialiser: start, 4 data bits LSB first, parity, stop; each bit CLKS_PER_BIT cycles.
// Start bit appears the cycle after acceptance; ready_out only in IDLE, valid_in while busy is dropped.
// Optional PARITY_TX_SEG_EN adds a 7-segment E/O parity indicator on hex.
module parity_tx
  import parity_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int ODD_PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy
`ifdef PARITY_TX_SEG_EN
  ,
  output logic [6:0] hex
`endif
);

  state_e     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic [1:0] idx_q, idx_d;
  logic       accept;
  logic       bit_done;
  logic       parity_bit;

  assign ready_out  = (state_q == IDLE);
  assign busy       = !ready_out;
  assign accept     = valid_in && ready_out;
  assign parity_bit = (^data_q) ^ (ODD_PARITY != 0);

  parity_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept),
    .run_i     (busy),
    .bit_done_o(bit_done)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          data_d  = data_in;
          idx_d   = 2'd0;
        end
      end
      START:  if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = PARITY;
        end
      end
      PARITY: if (bit_done) state_d = STOP;
      STOP:   if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = data_q[idx_q];
      PARITY:  tx = parity_bit;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 4'd0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

`ifdef PARITY_TX_SEG_EN
  logic [6:0] hex_q;

  // Indicator reflects the nibble as accepted, independent of ODD_PARITY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= SEG_BLANK;
    end else if (accept) begin
      hex_q <= (^data_in) ? SEG_O : SEG_E;
    end
  end

  assign hex = hex_q;
`endif

endmodule

// File: tb/tb_parity_tx.sv
// Randomised bench for parity_tx: even and odd instances checked each cycle against a waveform-queue model.
module tb_parity_tx;
  import parity_tx_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       valid_in = 1'b0;
  logic       rdy_e, tx_e, busy_e;
  logic       rdy_o, tx_o, busy_o;
  logic [6:0] hex_e, hex_o;

  int n_chk = 0;
  int n_err = 0;

  bit         q_e[$];
  bit         q_o[$];
  logic [6:0] hex_exp = SEG_BLANK;

  always #5 clk = ~clk;

  parity_tx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_e), .tx(tx_e), .busy(busy_e)
`ifdef PARITY_TX_SEG_EN
    , .hex(hex_e)
`endif
  );

  parity_tx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_o), .tx(tx_o), .busy(busy_o)
`ifdef PARITY_TX_SEG_EN
    , .hex(hex_o)
`endif
  );

`ifndef PARITY_TX_SEG_EN
  assign hex_e = SEG_BLANK;
  assign hex_o = SEG_BLANK;
`endif

  // Model: on acceptance, enqueue the whole line waveform of the frame; one entry consumed per cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_e.delete();
      q_o.delete();
      hex_exp = SEG_BLANK;
    end else if (q_e.size() == 0) begin
      if (valid_in) begin
        bit frame[FRAME_BITS];
        int ones;
        ones = $countones(data_in);
        frame[0] = 1'b0;
        for (int i = 0; i < 4; i++) frame[i+1] = data_in[i];
        frame[5] = ones[0];
        frame[6] = 1'b1;
        for (int b = 0; b < FRAME_BITS; b++) begin
          for (int c = 0; c < CPB; c++) begin
            q_e.push_back(frame[b]);
            q_o.push_back(b == 5 ? ~frame[b] : frame[b]);
          end
        end
        hex_exp = ones[0] ? SEG_O : SEG_E;
      end
    end else begin
      void'(q_e.pop_front());
      void'(q_o.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_idle;
    exp_idle = (q_e.size() == 0);
    chk("tx_even", tx_e, exp_idle ? 1'b1 : q_e[0]);
    chk("tx_odd", tx_o, exp_idle ? 1'b1 : q_o[0]);
    chk("ready_even", rdy_e, exp_idle);
    chk("ready_odd", rdy_o, exp_idle);
    chk("busy_even", busy_e, !exp_idle);
    chk("busy_odd", busy_o, !exp_idle);
`ifdef PARITY_TX_SEG_EN
    chk("hex_even", hex_e, hex_exp);
    chk("hex_odd", hex_o, hex_exp);
`endif
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [3:0] d);
    valid_in = 1'b1;
    data_in  = d;
    step();
    valid_in = 1'b0;
    data_in  = ~d;
    repeat (FRAME_BITS * CPB + 2) step();
  endtask

  initial begin
    #2;
    chk("reset_tx", tx_e, 1'b1);
    chk("reset_ready", rdy_e, 1'b1);
    chk("reset_busy", busy_e, 1'b0);
`ifdef PARITY_TX_SEG_EN
    chk("reset_hex", hex_e, SEG_BLANK);
`endif
    step();
    rst_n = 1'b1;

    send(4'b1011);
    send(4'b0000);
    send(4'b0110);
    send(4'b0111);

    // Back-to-back offers with data_in changing every cycle.
    valid_in = 1'b1;
    for (int i = 0; i < 2 * (FRAME_BITS * CPB + 1) + 4; i++) begin
      data_in = 4'($urandom);
      step();
    end
    valid_in = 1'b0;
    repeat (FRAME_BITS * CPB + 2) step();

    // Abort during DATA, then accept on the first edge after release.
    valid_in = 1'b1;
    data_in  = 4'b1110;
    step();
    valid_in = 1'b0;
    repeat (CPB + 2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_e, 1'b1);
    chk("abort_ready", rdy_e, 1'b1);
    chk("abort_busy", busy_e, 1'b0);
    step();
    rst_n    = 1'b1;
    valid_in = 1'b1;
    data_in  = 4'b0101;
    step();
    valid_in = 1'b0;
    repeat (FRAME_BITS * CPB + 2) step();

    for (int i = 0; i < 600; i++) begin
      valid_in = ($urandom_range(0, 3) == 0);
      data_in  = 4'($urandom);
      step();
    end
    valid_in = 1'b0;
    repeat (FRAME_BITS * CPB + 2) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
